top_level_keyboard: RTL and testbench
=====================================

TOP_LEVEL_KEYBOARD -- requirements
Module: top_level_keyboard

Interface
REQ-001 Parameter FILTER_LEN, default 4, meaning: consecutive identical system-clock samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, meaning: system-clock cycles with no filtered falling edge after which a partial frame is discarded.
REQ-003 clock  input  1  system clock; the block has one clock and every register is clocked on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 kclock  input  1  PS/2 clock from the keyboard, asynchronous, idle high.
REQ-006 kdata  input  1  PS/2 data from the keyboard, asynchronous, idle high.
REQ-007 keycodeout  output  32  history of the last four received scan-code bytes, newest byte in [7:0].
REQ-008 key_valid  output  1  one-cycle pulse in the same cycle keycodeout takes a new byte.
REQ-009 frame_err  output  1  one-cycle pulse when a complete frame is rejected.

Function
REQ-010 kclock and kdata SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The filtered kclock SHALL go low only after FILTER_LEN consecutive synchronized samples of 0, and go high only after FILTER_LEN consecutive samples of 1; otherwise it holds its level.
REQ-012 A falling edge SHALL be the filtered kclock changing from 1 to 0; synchronized kdata is sampled in that cycle.
REQ-013 Frames are 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1); a 4-bit counter counts 0..10.
REQ-014 At bit 0, a sampled start bit of 1 SHALL be ignored and the counter kept at 0, so that a later edge can resynchronize.
REQ-015 After the 11th sample, the frame SHALL be accepted if start=0, stop=1 and the parity check (REQ-022) passes.
REQ-016 On acceptance, the cycle after the stop-bit edge SHALL update keycodeout to {keycodeout[23:0], data_byte} and pulse key_valid.
REQ-017 Every accepted frame SHALL shift in its byte, including repeats and 0xF0/0xE0 prefixes; no de-duplication is performed.
REQ-018 A rejected complete frame SHALL leave keycodeout unchanged, pulse frame_err one cycle, and return the counter to 0.
REQ-019 With the counter nonzero, TIMEOUT_CYCLES cycles without a falling edge SHALL clear the counter, with no outputs changed.
REQ-020 When no falling edges occur (kclock held high or held low), keycodeout SHALL hold its value indefinitely.

Reset
REQ-021 While reset is high at a rising clock edge, the following SHALL be forced: keycodeout=0x00000000, key_valid=0, frame_err=0, bit counter=0, timeout counter=0, synchronizers and filtered clock=1, and filter counter=0; reset mid-frame discards the partial frame.

Configuration
REQ-022 Macro PS2_PARITY_CHECK_EN: when defined, a frame is accepted only if the 8 data bits plus the parity bit contain an odd number of ones; when undefined, the parity bit is sampled but ignored and only start/stop decide acceptance.

Verification
REQ-023 Reset, then kclock=1 with kdata toggling 1/0/1 for 100 clocks -> keycodeout=0x00000000, no key_valid.
REQ-024 Send frame 0x1C (parity 0, stop 1) with the PS/2 clock half-period at 20 system clocks or more -> keycodeout=0x0000001C, one key_valid pulse.
REQ-025 Send 0x1C, 0xF0, 0x1C, 0x32, 0x29 -> keycodeout=0x1CF01C32 after the fourth byte, then 0xF01C3229 after the fifth.
REQ-026 Send 0x1C with a wrong parity bit -> with PS2_PARITY_CHECK_EN, frame_err pulses and keycodeout is unchanged; without the macro, keycodeout ends in 0x1C.
REQ-027 Send 5 bits, idle TIMEOUT_CYCLES+10 cycles, then send a full 0x32 frame -> keycodeout ends in 0x32 with no frame_err; assert reset mid-frame -> keycodeout=0.
REQ-028 Add 1-2 clock glitches (shorter than FILTER_LEN) on kclock while it is high -> no edge is detected and the received bytes are unchanged.

Source files
------------

// File: rtl/top_level_keyboard.sv
// PS/2 keyboard receiver: synchronizes and filters kclock, deserializes 11-bit frames
// and keeps the last four scan-code bytes. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module top_level_keyboard #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        kclock,
  input  logic        kdata,
  output logic [31:0] keycodeout,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {S_IDLE, S_RECV} state_t;

  logic          kclk_meta, kclk_sync, kdat_meta, kdat_sync;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state, state_nx;
  logic [3:0]    bit_cnt, bit_nx;
  logic [7:0]    data_sr, data_nx;
  logic          par_bit, par_nx;
  logic [TW-1:0] to_cnt, to_nx;
  logic [31:0]   kc_nx;
  logic          kv_nx, fe_nx;
  logic          parity_ok;

  // Synchronizers and glitch filter on the PS/2 clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      kclk_meta <= 1'b1;
      kclk_sync <= 1'b1;
      kdat_meta <= 1'b1;
      kdat_sync <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      kclk_meta <= kclock;
      kclk_sync <= kclk_meta;
      kdat_meta <= kdata;
      kdat_sync <= kdat_meta;
      filt_prev <= filt_clk;
      if (kclk_sync != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= kclk_sync;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{data_sr, par_bit};
`else
  // The parity bit is still captured so the frame shape is identical; it never blocks acceptance.
  assign parity_ok = (^{data_sr, par_bit}) | 1'b1;
`endif

  // Frame deserializer: bit_cnt tracks the next bit index (0 = waiting for start).
  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    data_nx  = data_sr;
    par_nx   = par_bit;
    to_nx    = to_cnt;
    kc_nx    = keycodeout;
    kv_nx    = 1'b0;
    fe_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        to_nx = '0;
        if (fall && !kdat_sync) begin
          state_nx = S_RECV;
          bit_nx   = 4'd1;
        end
      end
      S_RECV: begin
        if (fall) begin
          to_nx  = '0;
          bit_nx = bit_cnt + 4'd1;
          if (bit_cnt <= 4'd8) begin
            data_nx = {kdat_sync, data_sr[7:1]};
          end else if (bit_cnt == 4'd9) begin
            par_nx = kdat_sync;
          end else begin
            state_nx = S_IDLE;
            bit_nx   = 4'd0;
            if (kdat_sync && parity_ok) begin
              kc_nx = {keycodeout[23:0], data_sr};
              kv_nx = 1'b1;
            end else begin
              fe_nx = 1'b1;
            end
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nx = S_IDLE;
          bit_nx   = 4'd0;
          to_nx    = '0;
        end else begin
          to_nx = to_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        bit_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= 4'd0;
      data_sr    <= 8'h00;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      keycodeout <= 32'h0000_0000;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_nx;
      data_sr    <= data_nx;
      par_bit    <= par_nx;
      to_cnt     <= to_nx;
      keycodeout <= kc_nx;
      key_valid  <= kv_nx;
      frame_err  <= fe_nx;
    end
  end

endmodule

// File: tb/tb_top_level_keyboard.sv
// Bench for top_level_keyboard: directed PS/2 frames against a byte-history model.
module tb_top_level_keyboard;

  localparam int TMO = 1000;

  logic        clock;
  logic        reset;
  logic        kclock;
  logic        kdata;
  logic [31:0] keycodeout;
  logic        key_valid;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int exp_err   = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] model_kc = 32'h0;
  logic [31:0] snap;

  top_level_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .kclock     (kclock),
    .kdata      (kdata),
    .keycodeout (keycodeout),
    .key_valid  (key_valid),
    .frame_err  (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every key_valid consumes one expected byte into the 4-byte history.
  always @(negedge clock) begin
    if (reset) begin
      model_kc = 32'h0;
      exp_q.delete();
    end else begin
      if (key_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_key_valid: got byte %h expected none", keycodeout[7:0]);
        end else begin
          model_kc = {model_kc[23:0], exp_q.pop_front()};
        end
      end
      if (frame_err) err_cnt++;
      check("keycodeout_model", keycodeout, model_kc);
      check("pulse_overlap", {31'd0, key_valid & frame_err}, 32'd0);
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge clock);
    kdata = b;
    if (glitch) begin
      kclock = 1'b0;
      repeat (2) @(negedge clock);
      kclock = 1'b1;
      repeat (10) @(negedge clock);
    end else begin
      repeat (12) @(negedge clock);
    end
    kclock = 1'b0;
    repeat (25) @(negedge clock);
    kclock = 1'b1;
    repeat (13) @(negedge clock);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) ps2_bit(f[i], glitch);
    kdata = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
    bit accepted;
    accepted = !bad_par;
`ifndef PS2_PARITY_CHECK_EN
    accepted = 1'b1;
`endif
    if (accepted) exp_q.push_back(b);
    else exp_err++;
    send_bits(mk_frame(b, bad_par), 11, glitch);
    repeat (30) @(negedge clock);
    #1;
    check("byte_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    kclock = 1'b1;
    kdata  = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    check("reset_keycodeout", keycodeout, 32'h0);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Data activity with the clock idle must not produce bytes.
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      kdata = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    kdata = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    check("idle_keycodeout", keycodeout, 32'h0);
    check("idle_valid_cnt", valid_cnt, 32'd0);

    send_byte(8'h1C, 1'b0, 1'b0);
    check("first_byte", keycodeout, 32'h0000001C);
    check("first_valid_cnt", valid_cnt, 32'd1);

    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    check("four_bytes", keycodeout, 32'h1CF01C32);
    send_byte(8'h29, 1'b0, 1'b0);
    check("five_bytes", keycodeout, 32'hF01C3229);

    send_byte(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("bad_parity_kept", keycodeout, 32'hF01C3229);
    check("bad_parity_err", err_cnt, 32'd1);
`else
    check("bad_parity_ignored", keycodeout, 32'h1C32291C);
    check("bad_parity_no_err", err_cnt, 32'd0);
`endif

    // Short kclock glitches while idle, then a frame with glitches in every high phase.
    snap = model_kc;
    @(negedge clock); kclock = 1'b0; @(negedge clock); kclock = 1'b1;
    repeat (10) @(negedge clock);
    kclock = 1'b0; repeat (2) @(negedge clock); kclock = 1'b1;
    repeat (20) @(negedge clock);
    #1;
    check("glitch_hold", keycodeout, snap);
    send_byte(8'h55, 1'b0, 1'b1);
    check("glitch_frame", keycodeout, {snap[23:0], 8'h55});

    // Partial frame abandoned by timeout, then a clean frame.
    snap = {31'd0, 1'b0} + err_cnt;
    send_bits(mk_frame(8'h1C, 1'b0), 5, 1'b0);
    repeat (TMO + 10) @(negedge clock);
    send_byte(8'h32, 1'b0, 1'b0);
    check("timeout_resync", {24'd0, keycodeout[7:0]}, 32'h32);
    check("timeout_no_err", err_cnt, snap);

    // Reset in the middle of a frame.
    send_bits(mk_frame(8'h29, 1'b0), 5, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    check("midframe_reset", keycodeout, 32'h0);
    check("final_err_cnt", err_cnt, exp_err);
    check("final_pending", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
